// File: rtl/bnn_pkg.sv
// bnn_pkg
// Shared definitions for the binarised XNOR layer.
//   - Default geometry (beat width, beats per vector, neuron count).
//   - Controller state enumeration used by bnn_xnor_layer.
package bnn_pkg;

    localparam int DEF_IN_W    = 8;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_NEURONS = 8;

    // LOAD gathers beats, COMPUTE evaluates one neuron per cycle,
    // OUTPUT presents the result vector until it is taken.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

endpackage

// File: rtl/bnn_popcount.sv
// bnn_popcount
// Combinational XNOR-popcount: counts the bit positions where the activation
// vector and the weight vector agree.
//   x    in  VW     activation vector
//   w    in  VW     weight vector
//   cnt  out CNT_W  number of agreeing bit positions (0..VW)
module bnn_popcount #(
    parameter int VW    = 32,
    parameter int CNT_W = $clog2(VW + 1)
) (
    input  logic [VW-1:0]    x,
    input  logic [VW-1:0]    w,
    output logic [CNT_W-1:0] cnt
);

    logic [VW-1:0] match;

    assign match = ~(x ^ w);

    // Ripple accumulation of the agreement bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < VW; i++) begin
            cnt = cnt + CNT_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_xnor_layer.sv
// bnn_xnor_layer
// One binarised fully-connected layer. An activation vector arrives as BEATS
// beats of IN_W bits, then each neuron is evaluated in turn by a single shared
// XNOR-popcount unit and compared against its threshold. The NEURONS result
// bits are offered on a valid/ready output stream.
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_we/addr/weight/thresh per-neuron weight and threshold write port
//   in_valid/ready/data/last  activation beat stream (beat 0 = LSBs)
//   out_valid/ready/data      result vector stream
//   busy                      high while computing or holding a result
//   frame_err, cfg_err        sticky error flags, cleared by err_clr
module bnn_xnor_layer
    import bnn_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int BEATS   = DEF_BEATS,
    parameter int NEURONS = DEF_NEURONS,
    localparam int VW     = IN_W * BEATS,
    localparam int CNT_W  = $clog2(VW + 1),
    localparam int AW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [VW-1:0]      cfg_weight,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NEURONS-1:0] out_data,
    output logic               busy,
    output logic               frame_err,
    output logic               cfg_err,
    input  logic               err_clr
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW-1:0] LAST_N    = AW'(NEURONS - 1);
    localparam logic [AW:0]   N_LIMIT   = (AW + 1)'(NEURONS);

    state_t             state;
    state_t             state_nxt;
    logic [BW-1:0]      beat_cnt;
    logic [AW-1:0]      n;
    logic [VW-1:0]      x;
    logic [VW-1:0]      weight [NEURONS];
    logic [CNT_W-1:0]   thresh [NEURONS];
    logic [CNT_W-1:0]   match_cnt;
    logic               fire;
    logic               in_fire;
    logic               out_fire;
    logic               last_beat;
    logic               early_last;
    logic               missing_last;
    logic               cfg_addr_ok;
    logic               cfg_apply;
    logic               cfg_bad;

    assign in_ready     = (state == ST_LOAD);
    assign busy         = (state != ST_LOAD);
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign last_beat    = (beat_cnt == LAST_BEAT);
    assign early_last   = in_fire && in_last && !last_beat;
    assign missing_last = in_fire && !in_last && last_beat;

    // Weights must not change under the running evaluation, so writes are
    // refused while computing, as are writes to neurons that do not exist.
    assign cfg_addr_ok  = ({1'b0, cfg_addr} < N_LIMIT);
    assign cfg_apply    = cfg_we && cfg_addr_ok && (state != ST_COMPUTE);
    assign cfg_bad      = cfg_we && (!cfg_addr_ok || (state == ST_COMPUTE));

    bnn_popcount #(
        .VW    (VW),
        .CNT_W (CNT_W)
    ) u_popcount (
        .x   (x),
        .w   (weight[n]),
        .cnt (match_cnt)
    );

    // Threshold 0 always fires and a threshold above VW can never be reached.
    assign fire = (match_cnt >= thresh[n]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:    if (in_fire && last_beat) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (n == LAST_N)          state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (out_fire)             state_nxt = ST_LOAD;
            default:                              state_nxt = ST_LOAD;
        endcase
    end

    // Datapath. The first OUTPUT cycle lets the final result bit settle into
    // out_data before out_valid rises, so out_valid is a clean register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            n         <= '0;
            x         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (early_last) begin
                            beat_cnt <= '0;
                            x        <= '0;
                        end else begin
                            x[beat_cnt*IN_W +: IN_W] <= in_data;
                            if (last_beat) begin
                                beat_cnt <= '0;
                                n        <= '0;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_COMPUTE: begin
                    out_data[n] <= fire;
                    n           <= (n == LAST_N) ? '0 : n + 1'b1;
                end
                ST_OUTPUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NEURONS; i++) begin
                weight[i] <= '0;
                thresh[i] <= '0;
            end
        end else if (cfg_apply) begin
            weight[cfg_addr] <= cfg_weight;
            thresh[cfg_addr] <= cfg_thresh;
        end
    end

    // Sticky flags: a new error event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (early_last || missing_last) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (cfg_bad) begin
                cfg_err <= 1'b1;
            end else if (err_clr) begin
                cfg_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_xnor_layer.sv
// tb_bnn_xnor_layer
// Directed self-checking bench for bnn_xnor_layer at IN_W=8, BEATS=4,
// NEURONS=8. Expected result vectors are hand-computed from the weights,
// thresholds and activations written below.
module tb_bnn_xnor_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_weight;
    logic [5:0]  cfg_thresh;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        frame_err;
    logic        cfg_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;
    int cyc;
    bit found;

    bnn_xnor_layer #(
        .IN_W    (8),
        .BEATS   (4),
        .NEURONS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_weight (cfg_weight),
        .cfg_thresh (cfg_thresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .cfg_err    (cfg_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams nbeats beats of vec (beat 0 from the LSBs); in_last is raised on
    // beat index last_at (pass -1 for no in_last at all).
    task automatic applyStimulus(input logic [31:0] vec, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_data  = vec[k*8 +: 8];
            in_last  = (k == last_at);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic cfgWrite(input int addr, input logic [31:0] w, input int t);
        cfg_we     = 1'b1;
        cfg_addr   = addr[2:0];
        cfg_weight = w;
        cfg_thresh = t[5:0];
        @(posedge clk); #1;
        cfg_we     = 1'b0;
    endtask

    task automatic waitValid(input int maxc, output int n_cyc, output bit got);
        n_cyc = 0;
        got   = 1'b0;
        while (n_cyc < maxc && !got) begin
            @(posedge clk); #1;
            n_cyc++;
            if (out_valid) got = 1'b1;
        end
    endtask

    task automatic acceptOutput();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulseClear();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_weight = '0; cfg_thresh = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        $display("[TB] all-ones weights, threshold 32");
        for (int i = 0; i < 8; i++) cfgWrite(i, 32'hFFFF_FFFF, 32);
        applyStimulus(32'hFFFF_FFFF, 4, 3);
        checkOutput("compute_busy", busy, 1);
        checkOutput("compute_in_ready", in_ready, 0);
        waitValid(40, cyc, found);
        checkOutput("ones_valid_seen", found, 1);
        checkOutput("ones_latency", cyc, 9);
        checkOutput("ones_data", out_data, 8'hFF);
        checkOutput("ones_frame_err", frame_err, 0);
        acceptOutput();
        checkOutput("accept_out_valid", out_valid, 0);
        checkOutput("accept_in_ready", in_ready, 1);
        checkOutput("accept_busy", busy, 0);
        checkOutput("accept_data_hold", out_data, 8'hFF);

        $display("[TB] mixed neurons, activation FF,FF,00,00");
        cfgWrite(0, 32'hFFFF_FFFF, 16);
        cfgWrite(1, 32'h0000_FFFF, 32);
        cfgWrite(2, 32'h0000_0000, 16);
        cfgWrite(3, 32'h0000_0000, 0);
        cfgWrite(4, 32'h0000_FFFF, 33);
        applyStimulus(32'h0000_FFFF, 4, 3);
        waitValid(40, cyc, found);
        checkOutput("mixed_valid_seen", found, 1);
        checkOutput("mixed_data", out_data, 8'h0F);
        acceptOutput();
        cfgWrite(0, 32'hFFFF_FFFF, 17);
        applyStimulus(32'h0000_FFFF, 4, 3);
        waitValid(40, cyc, found);
        checkOutput("thresh17_valid_seen", found, 1);
        checkOutput("thresh17_data", out_data, 8'h0E);
        acceptOutput();

        $display("[TB] early in_last then clean frame");
        applyStimulus(32'h0000_FFFF, 2, 1);
        checkOutput("early_frame_err", frame_err, 1);
        checkOutput("early_in_ready", in_ready, 1);
        checkOutput("early_busy", busy, 0);
        waitValid(12, cyc, found);
        checkOutput("early_no_valid", found, 0);
        applyStimulus(32'hFFFF_FFFF, 4, 3);
        waitValid(40, cyc, found);
        checkOutput("clean_valid_seen", found, 1);
        checkOutput("clean_data", out_data, 8'hE9);
        checkOutput("frame_err_sticky", frame_err, 1);
        acceptOutput();
        pulseClear();
        checkOutput("frame_err_cleared", frame_err, 0);

        $display("[TB] missing in_last on final beat");
        applyStimulus(32'hFFFF_0000, 4, -1);
        checkOutput("missing_frame_err", frame_err, 1);
        waitValid(40, cyc, found);
        checkOutput("missing_valid_seen", found, 1);
        checkOutput("missing_data", out_data, 8'h0C);
        acceptOutput();
        pulseClear();

        $display("[TB] config during compute, output back-pressure");
        applyStimulus(32'hFFFF_FFFF, 4, 3);
        err_clr = 1'b1;
        cfgWrite(3, 32'h0000_0000, 33);
        err_clr = 1'b0;
        checkOutput("compute_cfg_err", cfg_err, 1);
        waitValid(40, cyc, found);
        checkOutput("hold_valid_seen", found, 1);
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_data", out_data, 8'hE9);
            checkOutput("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        pulseClear();
        checkOutput("cfg_err_cleared", cfg_err, 0);
        cfgWrite(3, 32'h0000_0000, 33);
        checkOutput("output_cfg_no_err", cfg_err, 0);
        checkOutput("output_cfg_data", out_data, 8'hE9);
        acceptOutput();
        applyStimulus(32'hFFFF_FFFF, 4, 3);
        waitValid(40, cyc, found);
        checkOutput("newcfg_valid_seen", found, 1);
        checkOutput("newcfg_data", out_data, 8'hE1);
        acceptOutput();

        $display("[TB] reset during compute");
        applyStimulus(32'hFFFF_FFFF, 4, 3);
        cfgWrite(0, 32'h0000_0000, 33);
        checkOutput("pre_rst_cfg_err", cfg_err, 1);
        @(posedge clk); #1;
        checkOutput("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_cfg_err", cfg_err, 0);
        checkOutput("midrst_frame_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("postrst_in_ready", in_ready, 1);
        waitValid(15, cyc, found);
        checkOutput("postrst_no_valid", found, 0);
        applyStimulus(32'h1234_5678, 4, 3);
        waitValid(40, cyc, found);
        checkOutput("zero_w_valid_seen", found, 1);
        checkOutput("zero_w_latency", cyc, 9);
        checkOutput("zero_w_data", out_data, 8'hFF);
        acceptOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
